// File: rtl/vga_pkg.sv
// Shared definitions for the layered VGA output stage: default 640x480
// timing, a colour record and a helper that sums the four timing segments.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int COLOR_W_DEF  = 4;
    localparam int COORD_W_DEF  = 11;

    // Colour at the default channel width, ordered {r,g,b} like the pins.
    typedef struct packed {
        logic [COLOR_W_DEF-1:0] r;
        logic [COLOR_W_DEF-1:0] g;
        logic [COLOR_W_DEF-1:0] b;
    } rgb_t;

    // Length of a line (or frame) from its active, porch and sync segments.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_layered_output_if.sv
// Bundle between game logic (sprite/background setup) and the VGA output
// stage (sync and colour pins, frame strobe).
interface vga_layered_output_if
    import vga_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int COLOR_W     = COLOR_W_DEF
);
    logic [NUM_SPRITES*COORD_W-1:0]   spr_x;
    logic [NUM_SPRITES*COORD_W-1:0]   spr_y;
    logic [NUM_SPRITES-1:0]           spr_en;
    logic [NUM_SPRITES*3*COLOR_W-1:0] spr_rgb;
    logic [3*COLOR_W-1:0]             bg_rgb;
    logic                             hsync;
    logic                             vsync;
    logic [COLOR_W-1:0]               vga_red;
    logic [COLOR_W-1:0]               vga_green;
    logic [COLOR_W-1:0]               vga_blue;
    logic                             frame_tick;

    // Game-logic side: supplies the scene, observes the frame strobe.
    modport master (
        output spr_x, spr_y, spr_en, spr_rgb, bg_rgb,
        input  hsync, vsync, vga_red, vga_green, vga_blue, frame_tick
    );

    // Output-stage side.
    modport slave (
        input  spr_x, spr_y, spr_en, spr_rgb, bg_rgb,
        output hsync, vsync, vga_red, vga_green, vga_blue, frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters for the VGA output stage. Produces the current column and
// row, the active-video flag, raw (active-high) sync windows and the
// last-pixel-of-frame strobe, all decoded from the counter registers.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int COORD_W  = COORD_W_DEF
) (
    input  logic               vga_clock,
    input  logic               reset,
    output logic [COORD_W-1:0] h_cnt,
    output logic [COORD_W-1:0] v_cnt,
    output logic               de,
    output logic               hs,
    output logic               vs,
    output logic               eof
);
    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_cnt_reg;
    logic [COORD_W-1:0] v_cnt_reg;

    // Raster scan: column advances every clock, row advances on column wrap.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    assign h_cnt = h_cnt_reg;
    assign v_cnt = v_cnt_reg;
    assign de    = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    assign hs    = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
    assign vs    = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    assign eof   = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

endmodule

// File: rtl/vga_layered_output.sv
// VGA output stage compositing solid rectangular sprites over a background.
// Stage 0 is the raster counter, stage 1 registers per-sprite hit bits with
// the delayed DE/syncs, stage 2 registers the priority-muxed colour with the
// syncs, so colour and sync leave with the same two-cycle latency. Scene
// inputs are sampled once per frame so a frame never shows a half-updated
// scene.
module vga_layered_output
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int H_FP        = H_FP_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int H_BP        = H_BP_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int V_FP        = V_FP_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int V_BP        = V_BP_DEF,
    parameter bit SYNC_POL    = 1'b0,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int COORD_W     = COORD_W_DEF,
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16
) (
    input  logic                 vga_clock,
    input  logic                 reset,
    vga_layered_output_if.slave  bus
);
    localparam int RGB_W = 3 * COLOR_W;
    // Sprite extents use one extra bit so a sprite near the top of the
    // coordinate range clips instead of wrapping back to column/row 0.
    localparam logic [COORD_W:0] SPR_W_EXT = (COORD_W + 1)'(SPR_W);
    localparam logic [COORD_W:0] SPR_H_EXT = (COORD_W + 1)'(SPR_H);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               de;
    logic               hs;
    logic               vs;
    logic               eof;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .COORD_W  (COORD_W)
    ) u_timing (
        .vga_clock (vga_clock),
        .reset     (reset),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .de        (de),
        .hs        (hs),
        .vs        (vs),
        .eof       (eof)
    );

    logic [NUM_SPRITES*COORD_W-1:0] sh_x_reg;
    logic [NUM_SPRITES*COORD_W-1:0] sh_y_reg;
    logic [NUM_SPRITES-1:0]         sh_en_reg;
    logic [NUM_SPRITES*RGB_W-1:0]   sh_rgb_reg;
    logic [RGB_W-1:0]               sh_bg_reg;

    // Scene shadow: sampled only on the last pixel of the frame.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            sh_x_reg   <= '0;
            sh_y_reg   <= '0;
            sh_en_reg  <= '0;
            sh_rgb_reg <= '0;
            sh_bg_reg  <= '0;
        end else if (eof) begin
            sh_x_reg   <= bus.spr_x;
            sh_y_reg   <= bus.spr_y;
            sh_en_reg  <= bus.spr_en;
            sh_rgb_reg <= bus.spr_rgb;
            sh_bg_reg  <= bus.bg_rgb;
        end
    end

    logic [COORD_W:0]       h_ext;
    logic [COORD_W:0]       v_ext;
    logic [NUM_SPRITES-1:0] hit_next;
    logic [RGB_W-1:0]       spr_rgb_arr [NUM_SPRITES];

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            logic [COORD_W:0] x_lo;
            logic [COORD_W:0] x_hi;
            logic [COORD_W:0] y_lo;
            logic [COORD_W:0] y_hi;

            assign x_lo = {1'b0, sh_x_reg[gi*COORD_W +: COORD_W]};
            assign y_lo = {1'b0, sh_y_reg[gi*COORD_W +: COORD_W]};
            assign x_hi = x_lo + SPR_W_EXT;
            assign y_hi = y_lo + SPR_H_EXT;

            assign hit_next[gi] = sh_en_reg[gi]
                                && (h_ext >= x_lo) && (h_ext < x_hi)
                                && (v_ext >= y_lo) && (v_ext < y_hi);
            assign spr_rgb_arr[gi] = sh_rgb_reg[gi*RGB_W +: RGB_W];
        end
    endgenerate

    logic [NUM_SPRITES-1:0] hit_reg;
    logic                   de_d_reg;
    logic                   hs_d_reg;
    logic                   vs_d_reg;

    // Stage 1: hit bits travel with the matching DE and raw syncs.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            hit_reg  <= '0;
            de_d_reg <= 1'b0;
            hs_d_reg <= 1'b0;
            vs_d_reg <= 1'b0;
        end else begin
            hit_reg  <= hit_next;
            de_d_reg <= de;
            hs_d_reg <= hs;
            vs_d_reg <= vs;
        end
    end

    logic [RGB_W-1:0] rgb_next;

    // Lowest-index hit wins; anything outside active video is black.
    always_comb begin
        rgb_next = sh_bg_reg;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_reg[i]) begin
                rgb_next = spr_rgb_arr[i];
            end
        end
        if (!de_d_reg) begin
            rgb_next = '0;
        end
    end

    logic [RGB_W-1:0] rgb_reg;
    logic             hsync_reg;
    logic             vsync_reg;

    // Stage 2: colour and polarity-adjusted syncs leave together.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            rgb_reg   <= '0;
            hsync_reg <= ~SYNC_POL;
            vsync_reg <= ~SYNC_POL;
        end else begin
            rgb_reg   <= rgb_next;
            hsync_reg <= hs_d_reg ? SYNC_POL : ~SYNC_POL;
            vsync_reg <= vs_d_reg ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign bus.vga_red    = rgb_reg[RGB_W-1 -: COLOR_W];
    assign bus.vga_green  = rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign bus.vga_blue   = rgb_reg[COLOR_W-1:0];
    assign bus.hsync      = hsync_reg;
    assign bus.vsync      = vsync_reg;
    assign bus.frame_tick = eof;

endmodule

// File: tb/tb_vga_layered_output.sv
// Bench for vga_layered_output at a reduced raster (160x74 total) so several
// frames fit in a short run. Pixel probes come from a phase-tagged table; when
// the raster reaches a probe, its expected colour is queued and compared two
// cycles later when that pixel leaves the pipeline. Sync width/period and
// frame_tick spacing are checked continuously.
module tb_vga_layered_output;
    import vga_pkg::*;

    localparam int H_ACTIVE = 128, H_FP = 8, H_SYNC = 16, H_BP = 8;
    localparam int V_ACTIVE = 68,  V_FP = 2, V_SYNC = 2,  V_BP = 2;
    localparam int H_TOTAL  = 160;
    localparam int V_TOTAL  = 74;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int NS = 4, CW = 11, COLW = 4;

    logic vga_clock = 1'b0;
    logic reset     = 1'b0;

    vga_layered_output_if #(.NUM_SPRITES(NS), .COORD_W(CW), .COLOR_W(COLW)) bus ();

    vga_layered_output #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (1'b0), .COLOR_W (COLW), .COORD_W (CW),
        .NUM_SPRITES (NS), .SPR_W (16), .SPR_H (16)
    ) dut (
        .vga_clock (vga_clock),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 vga_clock = ~vga_clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tb_h  = 0;
    int tb_v  = 0;

    always @(posedge vga_clock) cyc <= cyc + 1;

    // Expected raster position of the DUT's stage-0 counters.
    always @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            tb_h <= 0;
            tb_v <= 0;
        end else if (tb_h == H_TOTAL - 1) begin
            tb_h <= 0;
            tb_v <= (tb_v == V_TOTAL - 1) ? 0 : tb_v + 1;
        end else begin
            tb_h <= tb_h + 1;
        end
    end

    typedef struct { int phase; int x; int y; rgb_t exp; } vec_t;
    typedef struct { int due; int x; int y; rgb_t exp; } sb_t;

    vec_t vecs[$];
    vec_t probes[$];
    sb_t  sb[$];

    function automatic rgb_t dut_rgb();
        return {bus.vga_red, bus.vga_green, bus.vga_blue};
    endfunction

    task automatic check_rgb(input string name, input rgb_t act, input rgb_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %03h expected %03h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input int phase, input int x, input int y, input logic [11:0] c);
        vec_t v;
        v.phase = phase; v.x = x; v.y = y; v.exp = c;
        vecs.push_back(v);
    endtask

    task automatic arm(input int phase);
        probes.delete();
        for (int k = 0; k < vecs.size(); k++)
            if (vecs[k].phase == phase) probes.push_back(vecs[k]);
    endtask

    task automatic set_sprite(input int i, input int x, input int y,
                              input logic en, input logic [11:0] c);
        bus.spr_x[i*CW +: CW]     = CW'(x);
        bus.spr_y[i*CW +: CW]     = CW'(y);
        bus.spr_en[i]             = en;
        bus.spr_rgb[i*12 +: 12]   = c;
    endtask

    task automatic wait_pos(input int x, input int y, input int budget);
        int n = 0;
        do begin
            @(negedge vga_clock);
            n++;
        end while (!(tb_h == x && tb_v == y) && n < budget);
        if (!(tb_h == x && tb_v == y)) begin
            total++;
            bad++;
            $display("FAIL wait_pos(%0d,%0d): not reached in %0d cycles", x, y, budget);
        end
    endtask

    // Called on the release negedge: counts clocks to the first hsync fall.
    task automatic first_hs_fall(input string name);
        int n = 0;
        while (bus.hsync !== 1'b0 && n < 2 * H_TOTAL) begin
            @(posedge vga_clock);
            n++;
            @(negedge vga_clock);
        end
        check_int(name, n, HS_START + 2);
    endtask

    // Scoreboard: compare due pixels, then queue any probe hit this cycle.
    always @(negedge vga_clock) begin : pixel_mon
        sb_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            $display("pixel (%0d,%0d): got %03h expected %03h", e.x, e.y, dut_rgb(), e.exp);
            check_rgb($sformatf("pixel(%0d,%0d)", e.x, e.y), dut_rgb(), e.exp);
        end
        if (reset) begin
            foreach (probes[k]) begin
                if (probes[k].x == tb_h && probes[k].y == tb_v) begin
                    e.due = cyc + 2; e.x = tb_h; e.y = tb_v; e.exp = probes[k].exp;
                    sb.push_back(e);
                end
            end
        end
    end

    logic hs_prev = 1'b1, vs_prev = 1'b1;
    int   hs_fall = 0, vs_fall = 0, last_tick = 0;
    bit   hs_valid = 0, vs_valid = 0, tick_valid = 0;

    // Sync width/period and frame_tick spacing, restarted by reset.
    always @(negedge vga_clock) begin : sync_mon
        if (!reset) begin
            hs_valid = 0; vs_valid = 0; tick_valid = 0;
            hs_prev = 1'b1; vs_prev = 1'b1;
        end else begin
            if (hs_prev && !bus.hsync) begin
                if (hs_valid) check_int("hsync_period", cyc - hs_fall, H_TOTAL);
                hs_fall = cyc; hs_valid = 1;
            end
            if (!hs_prev && bus.hsync && hs_valid)
                check_int("hsync_width", cyc - hs_fall, H_SYNC);
            if (vs_prev && !bus.vsync) begin
                if (vs_valid) check_int("vsync_period", cyc - vs_fall, FRAME);
                vs_fall = cyc; vs_valid = 1;
            end
            if (!vs_prev && bus.vsync && vs_valid)
                check_int("vsync_width", cyc - vs_fall, V_SYNC * H_TOTAL);
            if (bus.frame_tick === 1'b1) begin
                if (tick_valid) check_int("frame_tick_spacing", cyc - last_tick, FRAME);
                last_tick = cyc; tick_valid = 1;
            end
            hs_prev = bus.hsync;
            vs_prev = bus.vsync;
        end
    end

    initial begin
        // Phase 0: first frame after reset, shadows still cleared.
        add(0, 100, 50, 12'h000); add(0, 20, 10, 12'h000); add(0, 0, 50, 12'h000);
        // Phase 1: sprite 0 at (100,50) red, sprites 2/3 overlap at (20,10).
        add(1, 100, 50, 12'hF00); add(1, 115, 65, 12'hF00); add(1, 110, 58, 12'hF00);
        add(1,  99, 50, 12'h00F); add(1, 116, 50, 12'h00F); add(1, 128, 50, 12'h000);
        add(1,   0, 50, 12'h00F); add(1,   7, 55, 12'h00F); add(1,  20, 10, 12'h0F0);
        add(1,  35, 25, 12'h0F0); add(1,  36, 10, 12'h00F); add(1,  20, 26, 12'h00F);
        add(1,  50, 70, 12'h000);
        // Phase 2: sprite 0 moved to x=40, sprite 2 disabled.
        add(2,  40, 50, 12'hF00); add(2,  55, 65, 12'hF00); add(2,  39, 50, 12'h00F);
        add(2,  56, 50, 12'h00F); add(2, 100, 50, 12'h00F); add(2,  20, 10, 12'hFFF);
        add(2,  35, 25, 12'hFFF); add(2,   0, 50, 12'h00F);
        // Phase 3: frame after mid-frame reset, shadows cleared again.
        add(3,  40, 50, 12'h000); add(3,  50, 60, 12'h000); add(3,  20, 10, 12'h000);
        // Phase 4: scene reloaded at the first frame_tick after that reset.
        add(4,  40, 50, 12'hF00); add(4,  39, 50, 12'h00F); add(4,  20, 10, 12'hFFF);

        bus.spr_x = '0; bus.spr_y = '0; bus.spr_en = '0; bus.spr_rgb = '0; bus.bg_rgb = '0;
        repeat (3) @(negedge vga_clock);
        check_rgb("reset_rgb", dut_rgb(), 12'h000);
        check_bit("reset_hsync", bus.hsync, 1'b1);
        check_bit("reset_vsync", bus.vsync, 1'b1);
        check_bit("reset_frame_tick", bus.frame_tick, 1'b0);

        set_sprite(0, 100,  50, 1'b1, 12'hF00);
        set_sprite(1, 2040, 50, 1'b1, 12'hFF0);
        set_sprite(2,  20,  10, 1'b1, 12'h0F0);
        set_sprite(3,  20,  10, 1'b1, 12'hFFF);
        bus.bg_rgb = 12'h00F;
        arm(0);
        reset = 1'b1;
        last_tick = cyc - 1; tick_valid = 1;
        first_hs_fall("first_hs_fall");

        wait_pos(H_TOTAL - 1, V_TOTAL - 1, FRAME + 10);
        arm(1);
        wait_pos(0, 34, FRAME);
        set_sprite(0, 40, 50, 1'b1, 12'hF00);
        bus.spr_en[2] = 1'b0;
        wait_pos(H_TOTAL - 1, V_TOTAL - 1, FRAME);
        arm(2);
        wait_pos(H_TOTAL - 1, V_TOTAL - 1, FRAME);
        probes.delete();

        // Mid-frame asynchronous reset while a sprite pixel is on screen.
        wait_pos(45, 50, FRAME);
        check_rgb("pre_reset_pixel", dut_rgb(), 12'hF00);
        #2 reset = 1'b0;
        #1;
        check_rgb("async_reset_rgb", dut_rgb(), 12'h000);
        check_bit("async_reset_hsync", bus.hsync, 1'b1);
        check_bit("async_reset_vsync", bus.vsync, 1'b1);
        check_bit("async_reset_tick", bus.frame_tick, 1'b0);
        sb.delete();
        arm(3);
        repeat (3) @(posedge vga_clock);
        @(negedge vga_clock);
        reset = 1'b1;
        last_tick = cyc - 1; tick_valid = 1;
        first_hs_fall("restart_hs_fall");
        wait_pos(H_TOTAL - 1, V_TOTAL - 1, FRAME);
        arm(4);
        wait_pos(0, 67, FRAME);
        repeat (4) @(negedge vga_clock);
        check_int("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
